step_count_uart_tx: RTL and testbench



---
 rtl/step_count_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_step_count_uart_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/step_count_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : step_count_uart_tx
// Purpose  : Reads the 16-bit step total and sends it as 8N1 UART bytes, high
//            byte first. Define STEP_TX_CHECKSUM_EN to append an XOR byte.
// Revision : 1.0
// ============================================================================
module step_count_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        report_req,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [15:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef STEP_TX_CHECKSUM_EN
    localparam logic [1:0]  c_LAST_BYTE = 2'd2;
`else
    localparam logic [1:0]  c_LAST_BYTE = 2'd1;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_rd_req, w_rd_req_nxt;
    logic        r_done, w_done_nxt;
    logic [15:0] r_baud, w_baud_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [7:0]  r_lo, w_lo_nxt;
    logic [1:0]  r_byte, w_byte_nxt;
`ifdef STEP_TX_CHECKSUM_EN
    logic [7:0]  r_chk, w_chk_nxt;
`endif
    logic        w_baud_last;

    assign w_baud_last = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_nxt     = r_tx;
        w_busy_nxt   = r_busy;
        w_rd_req_nxt = r_rd_req;
        w_done_nxt   = 1'b0;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_lo_nxt     = r_lo;
        w_byte_nxt   = r_byte;
`ifdef STEP_TX_CHECKSUM_EN
        w_chk_nxt    = r_chk;
`endif
        case (r_state)
            IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (report_req) begin
                    w_state_nxt  = READ;
                    w_busy_nxt   = 1'b1;
                    w_rd_req_nxt = 1'b1;
                end
            end
            READ: begin
                // The whole word is captured here so later register-file
                // updates cannot tear the frame in flight.
                if (rd_ack) begin
                    w_rd_req_nxt = 1'b0;
                    w_shift_nxt  = rd_data[15:8];
                    w_lo_nxt     = rd_data[7:0];
`ifdef STEP_TX_CHECKSUM_EN
                    w_chk_nxt    = rd_data[15:8] ^ rd_data[7:0];
`endif
                    w_byte_nxt   = 2'd0;
                    w_baud_nxt   = 16'd0;
                    w_tx_nxt     = 1'b0;
                    w_state_nxt  = START;
                end
            end
            START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = 16'd0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt  = r_baud + 16'd1;
                end
            end
            DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = 16'd0;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt = 16'd0;
                    if (r_byte == c_LAST_BYTE) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_byte_nxt  = r_byte + 2'd1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = START;
`ifdef STEP_TX_CHECKSUM_EN
                        w_shift_nxt = (r_byte == 2'd0) ? r_lo : r_chk;
`else
                        w_shift_nxt = r_lo;
`endif
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_rd_req <= 1'b0;
            r_done   <= 1'b0;
            r_baud   <= 16'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_lo     <= 8'd0;
            r_byte   <= 2'd0;
`ifdef STEP_TX_CHECKSUM_EN
            r_chk    <= 8'd0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_rd_req <= w_rd_req_nxt;
            r_done   <= w_done_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_lo     <= w_lo_nxt;
            r_byte   <= w_byte_nxt;
`ifdef STEP_TX_CHECKSUM_EN
            r_chk    <= w_chk_nxt;
`endif
        end
    end

    assign tx     = r_tx;
    assign busy   = r_busy;
    assign rd_req = r_rd_req;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_step_count_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_count_uart_tx
// Purpose  : Directed bench for step_count_uart_tx with a byte scoreboard.
// Revision : 1.0
// ============================================================================
module tb_step_count_uart_tx;

    localparam int CLKS = 4;
`ifdef STEP_TX_CHECKSUM_EN
    localparam int NBYTES = 3;
`else
    localparam int NBYTES = 2;
`endif

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        report_req = 1'b0;
    logic        rd_ack     = 1'b0;
    logic [15:0] rd_data    = 16'h0000;
    logic        rd_req;
    logic        tx;
    logic        busy;
    logic        done;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  sb[$];

    step_count_uart_tx #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .report_req (report_req),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_request();
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        check("req_busy", 64'(busy), 64'd1);
    endtask

    // Acknowledge after 'delay' further cycles; scoreboard the bytes to expect.
    task automatic ack_read(input logic [15:0] data, input int delay, input bit scramble);
        int cnt;
        cnt = 0;
        for (int i = 0; i < delay; i++) begin
            if (rd_req) cnt++;
            tick();
        end
        if (rd_req) cnt++;
        rd_ack  = 1'b1;
        rd_data = data;
        tick();
        rd_ack  = 1'b0;
        if (scramble) rd_data = 16'hFFFF;
        sb.push_back(data[15:8]);
        sb.push_back(data[7:0]);
`ifdef STEP_TX_CHECKSUM_EN
        sb.push_back(data[15:8] ^ data[7:0]);
`endif
        check("rd_req_cycles", 64'(cnt), 64'(delay + 1));
        check("rd_req_drop", 64'(rd_req), 64'd0);
        check("first_start", 64'(tx), 64'd0);
    endtask

    // Captures tx cycle by cycle from the first start bit through the done pulse.
    task automatic recv_frame(input bit spam, input bit req_in_done);
        logic [39:0] obs;
        logic [39:0] expw;
        logic [7:0]  eb;
        int          early_done;
        int          stray_req;
        int          bi;
        early_done = 0;
        stray_req  = 0;
        for (int b = 0; b < NBYTES; b++) begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            eb = (sb.size() > 0) ? sb.pop_front() : 8'h00;
            for (int k = 0; k < 10 * CLKS; k++) begin
                bi = k / CLKS;
                expw[k] = (bi == 0) ? 1'b0 : ((bi == 9) ? 1'b1 : eb[bi - 1]);
                obs[k]  = tx;
                if (done) early_done++;
                if (rd_req) stray_req++;
                report_req = spam && (k % 5 == 2);
                tick();
            end
            check($sformatf("byte%0d_wave_%02h", b, eb), 64'(obs), 64'(expw));
        end
        report_req = 1'b0;
        check("no_early_done", 64'(early_done), 64'd0);
        check("no_stray_rd_req", 64'(stray_req), 64'd0);
        check("done_pulse", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        check("tx_idle_at_done", 64'(tx), 64'd1);
        report_req = req_in_done;
        tick();
        report_req = 1'b0;
        check("done_one_cycle", 64'(done), 64'd0);
        check("rd_req_after_done", 64'(rd_req), 64'(req_in_done));
        check("busy_after_done", 64'(busy), 64'(req_in_done));
    endtask

    initial begin
        int act;
        // Reset held low for three edges
        reset = 1'b0;
        repeat (3) tick();
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!tx || busy || rd_req || done) act++;
        end
        check("idle_quiet", 64'(act), 64'd0);

        // Acknowledge outside READ is ignored
        rd_ack  = 1'b1;
        rd_data = 16'h1111;
        tick();
        rd_ack  = 1'b0;
        check("stray_ack_rd_req", 64'(rd_req), 64'd0);
        check("stray_ack_busy", 64'(busy), 64'd0);
        check("stray_ack_tx", 64'(tx), 64'd1);

        // Basic frame, ack five cycles after rd_req rises
        start_request();
        ack_read(16'h1234, 4, 1'b0);
        recv_frame(1'b0, 1'b0);

        // Data changes after capture; requests during transmission; request in done cycle
        start_request();
        ack_read(16'h00A5, 2, 1'b1);
        recv_frame(1'b1, 1'b1);
        ack_read(16'hFFFF, 3, 1'b0);
        recv_frame(1'b0, 1'b0);

        // Reset during DATA of byte 0
        start_request();
        ack_read(16'h5A5A, 1, 1'b0);
        repeat (10) tick();
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_tx", 64'(tx), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rd_req", 64'(rd_req), 64'd0);
        sb.delete();
        act = 0;
        for (int i = 0; i < 60; i++) begin
            if (!tx || busy || rd_req || done) act++;
            tick();
        end
        check("abort_quiet", 64'(act), 64'd0);

        // Fresh frame after abort, all-zero word
        start_request();
        ack_read(16'h0000, 0, 1'b0);
        recv_frame(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
